// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: frame sequencer; fetches one soft-bit word per trellis step, hands it to the ACS array, logs survivors, runs traceback.
// Latency: start -> src_rd_o next cycle; 3-cycle minimum step period; tb_done_i -> frame_done_o next cycle.
// Backpressure: stalls in WAIT_ACS/TRACE until acs_valid_i/tb_done_i; optional watchdog via VITERBI_CTRL_TIMEOUT_EN.
module viterbi_ctrl #(
    parameter int SRC_ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_an_i,
    input  logic                  rst_sync_i,
    input  logic                  start_i,
    input  logic                  tail_biting_en_i,
    input  logic [9:0]            infobit_length_i,
    input  logic [9:0]            decoding_length_i,
    output logic                  src_rd_o,
    output logic [SRC_ADDR_W-1:0] src_addr_o,
    input  logic [23:0]           src_rdata_i,
    output logic [23:0]           soft_data_o,
    output logic                  soft_data_valid_o,
    input  logic                  acs_valid_i,
    input  logic [63:0]           survivor_i,
    output logic                  pm_norm_en_o,
    output logic                  tb_wr_o,
    output logic [5:0]            tb_addr_o,
    output logic [63:0]           tb_wdata_o,
    output logic                  tb_start_o,
    input  logic                  tb_done_i,
    output logic                  busy_o,
`ifdef VITERBI_CTRL_TIMEOUT_EN
    output logic                  err_o,
`endif
    output logic                  frame_done_o
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WAIT_ACS, TRACE, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  l_q, l_d;          // information length, bounds the address wrap
    logic [9:0]  n_q, n_d;          // step count; tail-biting mode and D are folded in at start
    logic [9:0]  s_q, s_d;          // trellis step
    logic [9:0]  a_q, a_d;          // source address
    logic        zero_q, zero_d;    // zero-length frame: one settle cycle in DONE before the pulse
    logic [23:0] soft_q, soft_d;
    logic        tb_wr_q, tb_wr_d;
    logic        pm_q, pm_d;
    logic [5:0]  tb_addr_q, tb_addr_d;
    logic [63:0] tb_wdata_q, tb_wdata_d;
    logic        tb_start_q, tb_start_d;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    logic [7:0]  wd_q, wd_d;
    logic        err_q, err_d;
`endif

    // Next-state, counters and registered strobes; sync reset overrides everything last
    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        n_d        = n_q;
        s_d        = s_q;
        a_d        = a_q;
        zero_d     = zero_q;
        soft_d     = soft_q;
        tb_wr_d    = 1'b0;
        pm_d       = 1'b0;
        tb_addr_d  = tb_addr_q;
        tb_wdata_d = tb_wdata_q;
        tb_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    l_d = infobit_length_i;
                    if (tail_biting_en_i && (decoding_length_i > infobit_length_i))
                        n_d = decoding_length_i;
                    else
                        n_d = infobit_length_i;
                    s_d     = 10'd0;
                    a_d     = 10'd0;
                    zero_d  = (infobit_length_i == 10'd0);
                    state_d = (infobit_length_i == 10'd0) ? DONE : FETCH;
                end
            end
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                soft_d  = src_rdata_i;
                state_d = WAIT_ACS;
            end
            WAIT_ACS: begin
                if (acs_valid_i) begin
                    tb_wr_d    = 1'b1;
                    pm_d       = 1'b1;
                    tb_addr_d  = s_q[5:0];
                    tb_wdata_d = survivor_i;
                    if (s_q == n_q - 10'd1) begin
                        state_d = TRACE;
                    end else begin
                        s_d     = s_q + 10'd1;
                        a_d     = (a_q == l_q - 10'd1) ? 10'd0 : a_q + 10'd1;
                        state_d = FETCH;
                    end
                end
            end
            TRACE: begin
                // the final survivor write is still in flight on the first TRACE cycle
                tb_start_d = tb_wr_q;
                if (tb_done_i) state_d = DONE;
            end
            DONE: begin
                if (zero_q) zero_d = 1'b0;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef VITERBI_CTRL_TIMEOUT_EN
        err_d = 1'b0;
        wd_d  = 8'd0;
        if (((state_q == WAIT_ACS) || (state_q == TRACE)) && (state_d == state_q)) begin
            if (wd_q == 8'd254) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
`endif
        if (rst_sync_i) begin
            state_d    = IDLE;
            l_d        = 10'd0;
            n_d        = 10'd0;
            s_d        = 10'd0;
            a_d        = 10'd0;
            zero_d     = 1'b0;
            soft_d     = 24'd0;
            tb_wr_d    = 1'b0;
            pm_d       = 1'b0;
            tb_addr_d  = 6'd0;
            tb_wdata_d = 64'd0;
            tb_start_d = 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
            wd_d  = 8'd0;
            err_d = 1'b0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q    <= IDLE;
            l_q        <= 10'd0;
            n_q        <= 10'd0;
            s_q        <= 10'd0;
            a_q        <= 10'd0;
            zero_q     <= 1'b0;
            soft_q     <= 24'd0;
            tb_wr_q    <= 1'b0;
            pm_q       <= 1'b0;
            tb_addr_q  <= 6'd0;
            tb_wdata_q <= 64'd0;
            tb_start_q <= 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
            wd_q  <= 8'd0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            n_q        <= n_d;
            s_q        <= s_d;
            a_q        <= a_d;
            zero_q     <= zero_d;
            soft_q     <= soft_d;
            tb_wr_q    <= tb_wr_d;
            pm_q       <= pm_d;
            tb_addr_q  <= tb_addr_d;
            tb_wdata_q <= tb_wdata_d;
            tb_start_q <= tb_start_d;
`ifdef VITERBI_CTRL_TIMEOUT_EN
            wd_q  <= wd_d;
            err_q <= err_d;
`endif
        end
    end

    assign src_rd_o          = (state_q == FETCH);
    assign src_addr_o        = SRC_ADDR_W'(a_q);
    // SRAM data only arrives in CAPTURE, so pass it through then and hold the captured copy afterwards
    assign soft_data_o       = (state_q == CAPTURE) ? src_rdata_i : soft_q;
    assign soft_data_valid_o = (state_q == CAPTURE);
    assign pm_norm_en_o      = pm_q;
    assign tb_wr_o           = tb_wr_q;
    assign tb_addr_o         = tb_addr_q;
    assign tb_wdata_o        = tb_wdata_q;
    assign tb_start_o        = tb_start_q;
    assign busy_o            = (state_q != IDLE);
    assign frame_done_o      = (state_q == DONE) && !zero_q;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    assign err_o             = err_q;
`endif

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: directed frames against viterbi_ctrl with a synchronous SRAM, ACS and traceback responder.
// Latency: bench drives at negedge, samples 1 ns later.
// Backpressure: ACS/traceback response delays are per-scenario.
module tb_viterbi_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_an_i, rst_sync_i, start_i, tail_biting_en_i;
    logic [9:0]  infobit_length_i, decoding_length_i;
    logic        src_rd_o;
    logic [11:0] src_addr_o;
    logic [23:0] src_rdata_i, soft_data_o;
    logic        soft_data_valid_o, acs_valid_i, pm_norm_en_o, tb_wr_o, tb_start_o, tb_done_i;
    logic [63:0] survivor_i, tb_wdata_o;
    logic [5:0]  tb_addr_o;
    logic        busy_o, frame_done_o;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    logic        err_o;
`endif

    always #5 clk_i = ~clk_i;

    viterbi_ctrl #(.SRC_ADDR_W(12)) dut (
        .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i), .start_i(start_i),
        .tail_biting_en_i(tail_biting_en_i), .infobit_length_i(infobit_length_i),
        .decoding_length_i(decoding_length_i), .src_rd_o(src_rd_o), .src_addr_o(src_addr_o),
        .src_rdata_i(src_rdata_i), .soft_data_o(soft_data_o), .soft_data_valid_o(soft_data_valid_o),
        .acs_valid_i(acs_valid_i), .survivor_i(survivor_i), .pm_norm_en_o(pm_norm_en_o),
        .tb_wr_o(tb_wr_o), .tb_addr_o(tb_addr_o), .tb_wdata_o(tb_wdata_o), .tb_start_o(tb_start_o),
        .tb_done_i(tb_done_i), .busy_o(busy_o),
`ifdef VITERBI_CTRL_TIMEOUT_EN
        .err_o(err_o),
`endif
        .frame_done_o(frame_done_o)
    );

    int total = 0;
    int bad   = 0;

    int          src_addr_q[$], src_cyc_q[$], tba_q[$], wr_cyc_q[$];
    logic [63:0] tbd_q[$], surv_q[$];
    int          pm_cnt, pm_bad, soft_bad, start_cnt, start_cyc, fd_cnt, fd_cyc, busy_low, first_valid, err_cyc;
    logic        bb_busy_fd1, bb_rd_fd2;
    logic [127:0] snap;

    function automatic logic [23:0] mem(input int a);
        return 24'hC30000 + 24'(a);
    endfunction

    // One frame: start at t=0, SRAM data the cycle after each read, ACS acs_dly cycles after each
    // soft_data_valid_o (0 = never), tb_done_i done_dly cycles after tb_start_o.
    task automatic run_frame(input logic tbm, input int l, input int d, input int acs_dly, input int done_dly,
                             input int max_cyc, input int stray_t, input bit bb, input int rst_step);
        int acs_at, done_at, step, valids, last_addr, prev_addr;
        logic prev_rd;
        bit rst_pending;
        src_addr_q.delete(); src_cyc_q.delete(); tba_q.delete(); wr_cyc_q.delete(); tbd_q.delete(); surv_q.delete();
        pm_cnt = 0; pm_bad = 0; soft_bad = 0; start_cnt = 0; start_cyc = -1; fd_cnt = 0; fd_cyc = -1;
        busy_low = -1; first_valid = -1; err_cyc = -1; bb_busy_fd1 = 1'bx; bb_rd_fd2 = 1'bx; snap = '1;
        acs_at = -1; done_at = -1; step = 0; valids = 0; last_addr = 0; prev_addr = 0; prev_rd = 1'b0; rst_pending = 0;
        tail_biting_en_i = tbm; decoding_length_i = 10'(d); infobit_length_i = 10'(l);
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk_i);
            src_rdata_i = prev_rd ? mem(prev_addr) : 24'hBADBAD;
            if (rst_pending) rst_an_i = 1'b0;
            #1;
            if (rst_pending) begin
                snap = 128'({src_rd_o, src_addr_o, soft_data_o, soft_data_valid_o, pm_norm_en_o, tb_wr_o,
                              tb_addr_o, tb_wdata_o, tb_start_o, busy_o, frame_done_o});
                break;
            end
            if (src_rd_o) begin
                src_addr_q.push_back(int'(src_addr_o)); src_cyc_q.push_back(t); last_addr = int'(src_addr_o);
            end
            prev_rd = src_rd_o; prev_addr = int'(src_addr_o);
            if (soft_data_valid_o) begin
                valids++;
                if (soft_data_o !== mem(last_addr)) soft_bad++;
                if (first_valid < 0) first_valid = t;
                acs_at = (acs_dly > 0) ? t + acs_dly : -1;
                if (valids == rst_step + 1) rst_pending = 1;
            end
            if (tb_wr_o) begin
                tba_q.push_back(int'(tb_addr_o)); tbd_q.push_back(tb_wdata_o); wr_cyc_q.push_back(t);
                if (pm_norm_en_o !== 1'b1) pm_bad++;
            end
            if (pm_norm_en_o) pm_cnt++;
            if (tb_start_o) begin start_cnt++; start_cyc = t; done_at = t + done_dly; end
            if (frame_done_o) begin fd_cnt++; if (fd_cyc < 0) fd_cyc = t; end
            if (!busy_o && t > 0 && busy_low < 0) busy_low = t;
`ifdef VITERBI_CTRL_TIMEOUT_EN
            if (err_o && err_cyc < 0) err_cyc = t;
`endif
            if (bb && fd_cyc >= 0 && t == fd_cyc + 1) bb_busy_fd1 = busy_o;
            if (bb && fd_cyc >= 0 && t == fd_cyc + 2) bb_rd_fd2 = src_rd_o;
            // drive phase for this cycle
            start_i = (t == 0) || (t == stray_t) || (bb && fd_cyc >= 0 && (t == fd_cyc || t == fd_cyc + 1));
            infobit_length_i = (t == stray_t) ? 10'(l + 1) : 10'(l);
            acs_valid_i = (t == acs_at);
            if (acs_valid_i) begin
                survivor_i = {32'hACE00000 + 32'(step), 32'h5A5A0000 ^ 32'(step)};
                surv_q.push_back(survivor_i);
                step++;
            end else begin
                survivor_i = '1;
            end
            tb_done_i = (t == done_at);
            if (fd_cyc >= 0 && t >= fd_cyc + 2) break;
            if (err_cyc >= 0 && t >= err_cyc + 1) break;
        end
        start_i = 1'b0; acs_valid_i = 1'b0; tb_done_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if ({src_rd_o, soft_data_valid_o, pm_norm_en_o, tb_wr_o, tb_start_o} !== 5'b0) begin bad++;
            $display("FAIL reset_strobes got=%b want=00000", {src_rd_o, soft_data_valid_o, pm_norm_en_o, tb_wr_o, tb_start_o}); end
        total++; if ({src_addr_o, soft_data_o, tb_addr_o, tb_wdata_o} !== '0) begin bad++;
            $display("FAIL reset_buses addr=%h soft=%h tba=%h tbd=%h want=0", src_addr_o, soft_data_o, tb_addr_o, tb_wdata_o); end
        total++; if ({busy_o, frame_done_o} !== 2'b00) begin bad++;
            $display("FAIL reset_status busy=%b done=%b want=0,0", busy_o, frame_done_o); end
    endtask

    task automatic test_tail_bit();
        int wr_exp[5] = '{4, 7, 10, 13, 16};
        run_frame(1'b0, 5, 0, 1, 2, 200, -1, 1'b0, -1);
        total++; if (src_addr_q.size() != 5) begin bad++; $display("FAIL tbit_src_cnt got=%0d want=5", src_addr_q.size()); end
        for (int i = 0; i < 5 && i < src_addr_q.size(); i++) begin
            total++; if (src_addr_q[i] !== i || src_cyc_q[i] !== 1 + 3 * i) begin bad++;
                $display("FAIL tbit_src[%0d] addr=%0d cyc=%0d want addr=%0d cyc=%0d", i, src_addr_q[i], src_cyc_q[i], i, 1 + 3 * i); end
        end
        total++; if (first_valid !== 2 || soft_bad !== 0) begin bad++;
            $display("FAIL tbit_soft first_valid=%0d bad_words=%0d want 2,0", first_valid, soft_bad); end
        total++; if (tba_q.size() != 5) begin bad++; $display("FAIL tbit_wr_cnt got=%0d want=5", tba_q.size()); end
        for (int i = 0; i < 5 && i < tba_q.size(); i++) begin
            total++; if (tba_q[i] !== i || tbd_q[i] !== surv_q[i] || wr_cyc_q[i] !== wr_exp[i]) begin bad++;
                $display("FAIL tbit_wr[%0d] addr=%0d data=%h cyc=%0d want %0d,%h,%0d", i, tba_q[i], tbd_q[i], wr_cyc_q[i], i, surv_q[i], wr_exp[i]); end
        end
        total++; if (pm_cnt !== 5 || pm_bad !== 0) begin bad++; $display("FAIL tbit_pm cnt=%0d unpaired=%0d want 5,0", pm_cnt, pm_bad); end
        total++; if (start_cnt !== 1 || start_cyc !== 17) begin bad++; $display("FAIL tbit_tbstart cnt=%0d cyc=%0d want 1,17", start_cnt, start_cyc); end
        total++; if (fd_cnt !== 1 || fd_cyc !== 20 || busy_low !== 21) begin bad++;
            $display("FAIL tbit_done cnt=%0d cyc=%0d busy_low=%0d want 1,20,21", fd_cnt, fd_cyc, busy_low); end
    endtask

    task automatic test_tail_biting();
        run_frame(1'b1, 4, 10, 2, 1, 300, -1, 1'b0, -1);
        total++; if (src_addr_q.size() != 10 || tba_q.size() != 10) begin bad++;
            $display("FAIL tbite_cnt src=%0d wr=%0d want 10,10", src_addr_q.size(), tba_q.size()); end
        for (int i = 0; i < 10 && i < src_addr_q.size() && i < tba_q.size(); i++) begin
            total++; if (src_addr_q[i] !== i % 4 || tba_q[i] !== i || tbd_q[i] !== surv_q[i]) begin bad++;
                $display("FAIL tbite_step[%0d] src=%0d tba=%0d data=%h want %0d,%0d,%h", i, src_addr_q[i], tba_q[i], tbd_q[i], i % 4, i, surv_q[i]); end
        end
        total++; if (fd_cnt !== 1 || start_cnt !== 1 || soft_bad !== 0) begin bad++;
            $display("FAIL tbite_end done=%0d start=%0d softbad=%0d want 1,1,0", fd_cnt, start_cnt, soft_bad); end
    endtask

    task automatic test_short_decode();
        run_frame(1'b1, 6, 3, 1, 1, 200, -1, 1'b0, -1);
        total++; if (src_addr_q.size() != 6 || tba_q.size() != 6 || fd_cnt !== 1) begin bad++;
            $display("FAIL dlt_l_steps src=%0d wr=%0d done=%0d want 6,6,1", src_addr_q.size(), tba_q.size(), fd_cnt); end
        for (int i = 0; i < 6 && i < src_addr_q.size(); i++) begin
            total++; if (src_addr_q[i] !== i) begin bad++; $display("FAIL dlt_l_src[%0d] got=%0d want=%0d", i, src_addr_q[i], i); end
        end
    endtask

    task automatic test_long_frame();
        int wrong = 0;
        run_frame(1'b0, 70, 0, 1, 1, 400, -1, 1'b0, -1);
        total++; if (tba_q.size() != 70 || pm_cnt !== 70) begin bad++;
            $display("FAIL long_cnt wr=%0d pm=%0d want 70,70", tba_q.size(), pm_cnt); end
        for (int i = 0; i < tba_q.size(); i++) if (tba_q[i] !== i % 64 || src_addr_q[i] !== i) wrong++;
        total++; if (wrong !== 0) begin bad++; $display("FAIL long_addr_seq wrong_steps=%0d want=0", wrong); end
        total++; if (tba_q.size() > 64 && (tba_q[63] !== 63 || tba_q[64] !== 0)) begin bad++;
            $display("FAIL long_wrap tba63=%0d tba64=%0d want 63,0", tba_q[63], tba_q[64]); end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL long_done got=%0d want=1", fd_cnt); end
    endtask

    task automatic test_zero_len();
        run_frame(1'b0, 0, 0, 1, 1, 20, -1, 1'b0, -1);
        total++; if (src_addr_q.size() != 0 || tba_q.size() != 0 || start_cnt !== 0) begin bad++;
            $display("FAIL zero_activity src=%0d wr=%0d tbstart=%0d want 0,0,0", src_addr_q.size(), tba_q.size(), start_cnt); end
        total++; if (fd_cnt !== 1 || fd_cyc !== 2 || busy_low !== 3) begin bad++;
            $display("FAIL zero_done cnt=%0d cyc=%0d busy_low=%0d want 1,2,3", fd_cnt, fd_cyc, busy_low); end
    endtask

    task automatic test_start_while_busy();
        run_frame(1'b0, 3, 0, 1, 1, 100, 5, 1'b0, -1);
        total++; if (src_addr_q.size() != 3 || tba_q.size() != 3 || fd_cnt !== 1) begin bad++;
            $display("FAIL busy_start src=%0d wr=%0d done=%0d want 3,3,1", src_addr_q.size(), tba_q.size(), fd_cnt); end
        for (int i = 0; i < 3 && i < src_addr_q.size(); i++) begin
            total++; if (src_addr_q[i] !== i) begin bad++; $display("FAIL busy_src[%0d] got=%0d want=%0d", i, src_addr_q[i], i); end
        end
    endtask

    task automatic test_reset_mid();
        run_frame(1'b0, 8, 0, 6, 1, 100, -1, 1'b0, 2);
        total++; if (snap !== 128'd0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", snap); end
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", fd_cnt); end
        @(negedge clk_i); rst_an_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midreset_idle busy=%b want=0", busy_o); end
        run_frame(1'b0, 3, 0, 1, 1, 100, -1, 1'b0, -1);
        total++; if (src_addr_q.size() != 3 || tba_q.size() != 3 || fd_cnt !== 1) begin bad++;
            $display("FAIL midreset_rerun src=%0d wr=%0d done=%0d want 3,3,1", src_addr_q.size(), tba_q.size(), fd_cnt); end
        for (int i = 0; i < 3 && i < src_addr_q.size() && i < tba_q.size(); i++) begin
            total++; if (src_addr_q[i] !== i || tba_q[i] !== i) begin bad++;
                $display("FAIL midreset_rerun[%0d] src=%0d tba=%0d want %0d", i, src_addr_q[i], tba_q[i], i); end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 2, 0, 1, 1, 100, -1, 1'b1, -1);
        total++; if (fd_cnt !== 1 || bb_busy_fd1 !== 1'b0) begin bad++;
            $display("FAIL b2b_ignore done=%0d busy_after=%b want 1,0", fd_cnt, bb_busy_fd1); end
        total++; if (bb_rd_fd2 !== 1'b1) begin bad++; $display("FAIL b2b_accept src_rd=%b want=1", bb_rd_fd2); end
        @(negedge clk_i); rst_sync_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL syncreset_pre busy=%b want=1", busy_o); end
        @(negedge clk_i); rst_sync_i = 1'b0;
        #1;
        total++; if ({busy_o, src_rd_o, soft_data_valid_o, soft_data_o} !== 27'd0) begin bad++;
            $display("FAIL syncreset_post busy=%b rd=%b vld=%b soft=%h want 0", busy_o, src_rd_o, soft_data_valid_o, soft_data_o); end
    endtask

`ifdef VITERBI_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(1'b0, 2, 0, 0, 1, 400, -1, 1'b0, -1);
        total++; if (err_cyc !== 258 || busy_low !== 258 || fd_cnt !== 0) begin bad++;
            $display("FAIL timeout err_cyc=%0d busy_low=%0d done=%0d want 258,258,0", err_cyc, busy_low, fd_cnt); end
    endtask
`endif

    initial begin
        rst_an_i = 1'b0; rst_sync_i = 1'b0; start_i = 1'b0; tail_biting_en_i = 1'b0;
        infobit_length_i = 10'd0; decoding_length_i = 10'd0; src_rdata_i = 24'd0;
        acs_valid_i = 1'b0; survivor_i = 64'd0; tb_done_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        test_reset();
        rst_an_i = 1'b1;
        test_tail_bit();
        test_tail_biting();
        test_short_decode();
        test_long_frame();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef VITERBI_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame sequencer for the Viterbi decoder core. On a start pulse it latches the frame configuration and fetches one 24-bit soft-bit word per trellis step from the input-buffer SRAM. It hands each word to the BMU/ACS array with a one-cycle valid, waits for the ACS step-complete handshake, and then writes the 64 survivor bits to the traceback buffer while pulsing path-metric normalization. After the last step it launches traceback, waits for its completion, and reports frame completion.

## Interface
Parameters:
- SRC_ADDR_W, 12, input-buffer SRAM address width; must be ≥ 10.

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_an_i  in  1  asynchronous active-low reset.
- rst_sync_i  in  1  synchronous reset, active-high; same effect as rst_an_i, applied on the next clock edge.
- start_i  in  1  frame start pulse; ignored while busy_o=1.
- tail_biting_en_i  in  1  0: tail-bit frame, 1: tail-biting frame.
- infobit_length_i  in  10  information bits per frame; tail bits are included in tail-bit mode.
- decoding_length_i  in  10  trellis steps when tail-biting.
- src_rd_o  out  1  input-buffer read strobe.
- src_addr_o  out  SRC_ADDR_W  input-buffer read address.
- src_rdata_i  in  24  read data, valid the cycle after src_rd_o.
- soft_data_o  out  24  soft bits to the BMU array.
- soft_data_valid_o  out  1  one-cycle qualifier for soft_data_o.
- acs_valid_i  in  1  ACS step complete.
- survivor_i  in  64  survivor decisions, valid with acs_valid_i.
- pm_norm_en_o  out  1  normalization enable pulse.
- tb_wr_o  out  1  traceback-buffer write strobe.
- tb_addr_o  out  6  traceback-buffer address.
- tb_wdata_o  out  64  survivor word written to the traceback buffer.
- tb_start_o  out  1  traceback launch pulse.
- tb_done_i  in  1  traceback finished.
- busy_o  out  1  a frame is in progress.
- frame_done_o  out  1  one-cycle pulse at end of frame.
- err_o  out  1  timeout pulse; exists only with VITERBI_CTRL_TIMEOUT_EN.

## Operation
- States: IDLE, FETCH, CAPTURE, WAIT_ACS, TRACE, DONE.
- **IDLE**
  - On start_i, latch tail_biting_en_i, infobit_length_i (L) and decoding_length_i (D).
  - Compute the step count N: tail-bit mode N = L; tail-biting mode N = max(D, L).
  - Clear the step counter s and the source-address counter a.
  - If L = 0, go to DONE; otherwise go to FETCH.
- **FETCH**
  - src_rd_o=1, src_addr_o = a, zero-extended to SRC_ADDR_W.
  - Go to CAPTURE.
- **CAPTURE**
  - Register src_rdata_i into soft_data_o; soft_data_valid_o=1 for exactly this cycle.
  - Go to WAIT_ACS.
- **WAIT_ACS**
  - Hold until acs_valid_i=1.
  - On acs_valid_i, register survivor_i.
  - Next cycle: tb_wr_o=1, tb_addr_o = s[5:0] (wraps modulo 64), tb_wdata_o = captured word, pm_norm_en_o=1.
  - If s = N−1, go to TRACE; otherwise s←s+1, advance a, and go to FETCH.
  - Address advance: a←a+1, except a←0 when a = L−1, so tail-biting wraps over the information bits.
- **TRACE**
  - tb_start_o pulses on entry.
  - Hold until tb_done_i=1, then go to DONE.
- **DONE**
  - frame_done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in every state except IDLE.
- Counters s and a are 10 bits. N ≤ 1023 by construction; N is computed as an unsigned 10-bit compare/select.
- acs_valid_i outside WAIT_ACS and tb_done_i outside TRACE are ignored.
- Reset (rst_an_i low, or rst_sync_i high) mid-frame aborts the frame: return to IDLE with no frame_done_o.

## Timing
- All outputs reset to 0. soft_data_o, tb_wdata_o and the latched configuration also reset to 0.
- Start sampled at edge 0 gives: src_rd_o high in cycle 1, soft_data_valid_o in cycle 2, WAIT_ACS from cycle 3.
- acs_valid_i sampled at edge k gives tb_wr_o/pm_norm_en_o in cycle k+1, coincident with src_rd_o of the next step.
- Minimum step period is 3 cycles.
- tb_start_o is asserted in the cycle after the final tb_wr_o.
- tb_done_i sampled at edge m gives frame_done_o in cycle m+1 and busy_o low from cycle m+2.
- A start_i in the same cycle as frame_done_o is ignored. A start_i in the following cycle is accepted.

## Configuration
- Macro: VITERBI_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent in WAIT_ACS or TRACE and clears on every state change.
  - At 255 cycles: err_o pulses for one cycle, the FSM goes to IDLE, and no frame_done_o is issued.
- Undefined: no watchdog, no err_o port; the FSM waits indefinitely.

## Test plan
- Tail-bit frame: L=5, acs_valid_i 1 cycle after each soft_data_valid_o → src addresses 0..4, tb_addr 0..4, 5 pm_norm_en_o pulses, one tb_start_o, frame_done_o after tb_done_i.
- Tail-biting frame: L=4, D=10 → src addresses 0,1,2,3,0,1,2,3,0,1; tb_addr 0..9; tb_wdata_o equals survivor_i of each step.
- Long frame: L=70, tail-bit → tb_addr wraps 63→0 at step 64; 70 writes total.
- Edge cases:
  - L=0 → no src_rd_o or tb_wr_o; frame_done_o in cycle 2.
  - start_i while busy → ignored.
  - tail-biting with D<L (L=6, D=3) → N=6.
- Reset: assert rst_an_i low in WAIT_ACS at step 2 → all outputs 0 at once, busy_o=0, no frame_done_o; a new start runs cleanly from address 0.
- Timeout (with VITERBI_CTRL_TIMEOUT_EN): withhold acs_valid_i → err_o pulses after 255 cycles in WAIT_ACS, then IDLE.
